// File: rtl/countdown_seq_ctrl.sv
// Two-digit BCD countdown sequencer (99..00): prescaled ticks, preset load, start/pause/clear, expiry pulse.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (re-arm from the last loaded preset after expiry).
module countdown_seq_ctrl #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clki,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);
    localparam int unsigned PS_W = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          st;
    logic [PS_W-1:0] ps;
    logic [3:0]      pre_tens;
    logic [3:0]      pre_ones;
    logic            load_ok;
    logic            count_zero;
    logic            count_last;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [3:0]      sh_tens;
    logic [3:0]      sh_ones;
`endif

    // Out-of-range preset digits saturate at 9; loads are only honoured outside RUN.
    assign pre_tens   = (load_tens > 4'd9) ? 4'd9 : load_tens;
    assign pre_ones   = (load_ones > 4'd9) ? 4'd9 : load_ones;
    assign load_ok    = load && (st != RUN);
    assign count_zero = (tens == 4'd0) && (ones == 4'd0);
    assign count_last = (tens == 4'd0) && (ones <= 4'd1);
    assign state      = st;

    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            st      <= IDLE;
            tens    <= 4'd0;
            ones    <= 4'd0;
            ps      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            sh_tens <= 4'd0;
            sh_ones <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            if (clear) begin
                st      <= IDLE;
                tens    <= 4'd0;
                ones    <= 4'd0;
                ps      <= '0;
                running <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
                sh_tens <= 4'd0;
                sh_ones <= 4'd0;
`endif
            end else if (load_ok) begin
                tens <= pre_tens;
                ones <= pre_ones;
                ps   <= '0;
                if (st == DONE) begin
                    st <= IDLE;
                end
`ifdef COUNTDOWN_AUTORELOAD_EN
                sh_tens <= pre_tens;
                sh_ones <= pre_ones;
`endif
            end else begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            ps <= '0;
                            if (!count_zero) begin
                                st      <= RUN;
                                running <= 1'b1;
                            end else begin
                                st   <= DONE;
                                done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // Pause freezes the prescaler so the tick phase survives a resume.
                        if (pause) begin
                            st      <= PAUSE;
                            running <= 1'b0;
                        end else if (ps == PS_LAST) begin
                            ps <= '0;
                            if (count_last) begin
                                tens    <= 4'd0;
                                ones    <= 4'd0;
                                st      <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else if (ones == 4'd0) begin
                                ones <= 4'd9;
                                tens <= tens - 4'd1;
                            end else begin
                                ones <= ones - 4'd1;
                            end
                        end else begin
                            ps <= ps + PS_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            st      <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                        // Re-arm one cycle after expiry unless the stored preset is 00.
                        if (done && ((sh_tens != 4'd0) || (sh_ones != 4'd0))) begin
                            tens    <= sh_tens;
                            ones    <= sh_ones;
                            ps      <= '0;
                            st      <= RUN;
                            running <= 1'b1;
                        end
`endif
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Self-checking bench for countdown_seq_ctrl: directed scenarios with literal expectations,
// then randomized front-panel stimulus compared each cycle against an integer-count reference model.
module tb_countdown_seq_ctrl;
    localparam int TD = 4;
`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clki = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic [1:0] state;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: whole count as an integer 0..99, prescaler phase, mode 0..3.
    int m_cnt = 0;
    int m_ps = 0;
    int m_st = 0;
    int m_done = 0;
    int m_shadow = 0;
    int prev_done = 0;

    countdown_seq_ctrl #(.TICK_DIV(TD)) dut (
        .clki(clki), .reset(reset), .clear(clear), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .start(start), .pause(pause),
        .tens(tens), .ones(ones), .running(running), .done(done), .state(state)
    );

    always #5 clki = ~clki;

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clki);
    endtask

    task automatic expect_cnt(input string name, input int t, input int o, input int s);
        check({name, "_tens"}, 32'(tens), 32'(t));
        check({name, "_ones"}, 32'(ones), 32'(o));
        check({name, "_state"}, 32'(state), 32'(s));
    endtask

    // Model update on each active edge, following the input priority clear > load > pause > start.
    initial forever begin
        @(posedge clki or negedge reset);
        if (!reset) begin
            m_cnt = 0; m_ps = 0; m_st = 0; m_done = 0; m_shadow = 0;
        end else begin
            prev_done = m_done;
            m_done = 0;
            if (clear) begin
                m_st = 0; m_cnt = 0; m_ps = 0; m_shadow = 0;
            end else if (load && m_st != 1) begin
                m_cnt = 10 * clamp9(load_tens) + clamp9(load_ones);
                m_shadow = m_cnt;
                m_ps = 0;
                if (m_st == 3) m_st = 0;
            end else if (m_st == 0) begin
                if (start) begin
                    m_ps = 0;
                    if (m_cnt > 0) m_st = 1;
                    else begin m_st = 3; m_done = 1; end
                end
            end else if (m_st == 1) begin
                if (pause) m_st = 2;
                else if (m_ps == TD - 1) begin
                    m_ps = 0;
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin m_st = 3; m_done = 1; end
                end else m_ps = m_ps + 1;
            end else if (m_st == 2) begin
                if (start && !pause) m_st = 1;
            end else if (AUTO && prev_done != 0 && m_shadow != 0) begin
                m_cnt = m_shadow; m_st = 1; m_ps = 0;
            end
        end
    end

    // Continuous compare of every output against the model, away from the active edge.
    initial forever begin
        @(negedge clki);
        check("mdl_tens", 32'(tens), 32'(m_cnt / 10));
        check("mdl_ones", 32'(ones), 32'(m_cnt % 10));
        check("mdl_state", 32'(state), 32'(m_st));
        check("mdl_running", 32'(running), 32'(m_st == 1));
        check("mdl_done", 32'(done), 32'(m_done));
    end

    initial begin
        cyc(2);
        expect_cnt("rst", 0, 0, 0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        // Preset 12, count down through the borrow to expiry.
        load = 1'b1; load_tens = 4'd1; load_ones = 4'd2; cyc(1); load = 1'b0;
        expect_cnt("load12", 1, 2, 0);
        start = 1'b1; cyc(1); start = 1'b0;
        check("run_entry_state", 32'(state), 32'd1);
        check("run_entry_running", 32'(running), 32'd1);
        cyc(4); expect_cnt("tick1", 1, 1, 1);
        cyc(4); expect_cnt("tick2", 1, 0, 1);
        cyc(4); expect_cnt("borrow", 0, 9, 1);
        check("model_pin_09", 32'(m_cnt), 32'd9);
        cyc(36); expect_cnt("expire", 0, 0, 3);
        check("expire_done", 32'(done), 32'd1);
        check("expire_running", 32'(running), 32'd0);
        cyc(1);
        check("done_one_cycle", 32'(done), 32'd0);
        if (AUTO) expect_cnt("post_expire", 1, 2, 1);
        else      expect_cnt("post_expire", 0, 0, 3);
        clear = 1'b1; cyc(1); clear = 1'b0;
        expect_cnt("clear", 0, 0, 0);

        // Clamp, load ignored in RUN, pause with preserved phase.
        load = 1'b1; load_tens = 4'd12; load_ones = 4'd10; cyc(1); load = 1'b0;
        expect_cnt("clamp", 9, 9, 0);
        start = 1'b1; cyc(1); start = 1'b0;
        load = 1'b1; load_tens = 4'd3; load_ones = 4'd3; cyc(1); load = 1'b0;
        expect_cnt("load_in_run", 9, 9, 1);
        cyc(1); pause = 1'b1; cyc(1);
        expect_cnt("paused", 9, 9, 2);
        cyc(10); start = 1'b1; cyc(1); start = 1'b0;
        check("pause_wins", 32'(state), 32'd2);
        cyc(9); expect_cnt("frozen", 9, 9, 2);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        expect_cnt("resume", 9, 9, 1);
        cyc(1); expect_cnt("resume_p3", 9, 9, 1);
        cyc(1); expect_cnt("resume_tick", 9, 8, 1);
        clear = 1'b1; cyc(1); clear = 1'b0;

        // Start from 00 expires immediately; DONE ignores start; load leaves DONE.
        load = 1'b1; load_tens = 4'd0; load_ones = 4'd0; cyc(1); load = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        expect_cnt("zero_start", 0, 0, 3);
        check("zero_start_done", 32'(done), 32'd1);
        cyc(1); check("zero_done_drop", 32'(done), 32'd0);
        start = 1'b1; cyc(2); start = 1'b0;
        expect_cnt("done_hold", 0, 0, 3);
        load = 1'b1; load_tens = 4'd3; load_ones = 4'd8; cyc(1); load = 1'b0;
        expect_cnt("done_load", 3, 8, 0);

        // Asynchronous reset mid-run takes effect before the next clock edge.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(4); expect_cnt("at37", 3, 7, 1);
        #2 reset = 1'b0;
        #1 expect_cnt("async_rst", 0, 0, 0);
        check("async_rst_running", 32'(running), 32'd0);
        cyc(1); reset = 1'b1;

        if (AUTO) begin
            load = 1'b1; load_tens = 4'd0; load_ones = 4'd2; cyc(1); load = 1'b0;
            start = 1'b1; cyc(1); start = 1'b0;
            cyc(8); expect_cnt("ar_expire1", 0, 0, 3);
            check("ar_done1", 32'(done), 32'd1);
            cyc(1); expect_cnt("ar_reload1", 0, 2, 1);
            cyc(8); expect_cnt("ar_expire2", 0, 0, 3);
            cyc(1); expect_cnt("ar_reload2", 0, 2, 1);
            clear = 1'b1; cyc(1); clear = 1'b0;
            expect_cnt("ar_clear", 0, 0, 0);
        end

        // Randomized front-panel activity, checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            clear     = ($urandom_range(99) < 2);
            load      = ($urandom_range(99) < 6);
            pause     = ($urandom_range(99) < 8);
            start     = ($urandom_range(99) < 25);
            load_tens = 4'($urandom_range(15));
            load_ones = 4'($urandom_range(15));
            cyc(1);
        end
        clear = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
